// File: rtl/fp_special_result_packer.sv
// Output stage of the FP32 adder datapath.
// Decodes the special-case detector's select codes together with the operand
// sign/exponent fields and the normal-path sum, producing a packed IEEE-754
// single-precision word through a 2-stage valid/ready pipeline. It also
// provides exception flags, a sticky illegal-code error and saturating
// NaN/overflow counters for the sort engine's statistics.
//
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_valid / o_ready          upstream handshake (o_ready combinational)
//   i_sel_exp, i_sel_man       detector select codes
//   i_sign_a/i_exp_a/...       operand sign and exponent fields
//   i_norm_sign/exp/man        normal-path rounded result
//   o_valid / i_ready          downstream handshake
//   o_result                   packed {sign, exp, man}
//   o_flag_nan/inf/ovf         result class flags, qualified by o_valid
//   o_err                      sticky illegal select code seen
//   i_clr_cnt                  synchronous clear of counters and o_err
//   o_cnt_nan, o_cnt_ovf       saturating exception counters
module fp_special_result_packer #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_sel_exp,
  input  logic [1:0]               i_sel_man,
  input  logic                     i_sign_a,
  input  logic [EXP_W-1:0]         i_exp_a,
  input  logic                     i_sign_b,
  input  logic [EXP_W-1:0]         i_exp_b,
  input  logic                     i_norm_sign,
  input  logic [EXP_W:0]           i_norm_exp,
  input  logic [MAN_W-1:0]         i_norm_man,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [EXP_W+MAN_W:0]     o_result,
  output logic                     o_flag_nan,
  output logic                     o_flag_inf,
  output logic                     o_flag_ovf,
  output logic                     o_err,
  input  logic                     i_clr_cnt,
  output logic [CNT_W-1:0]         o_cnt_nan,
  output logic [CNT_W-1:0]         o_cnt_ovf
);

  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;

  // Result classes carried from S1 to S2
  localparam logic [2:0] K_NORM = 3'd0;
  localparam logic [2:0] K_ZERO = 3'd1;
  localparam logic [2:0] K_INF  = 3'd2;
  localparam logic [2:0] K_OVF  = 3'd3;
  localparam logic [2:0] K_NAN  = 3'd4;

  // Smallest biased exponent that no longer fits a finite result
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Operand B's exponent is implied by the detector's select codes
  logic unused_exp_b;
  assign unused_exp_b = ^i_exp_b;

  logic             s1_vld;
  logic [2:0]       s1_kind;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;

  logic             s2_load;
  logic             in_fire;
  logic             out_fire;

  logic             dec_illegal;
  logic [2:0]       dec_kind;
  logic             dec_sign;

  logic [RES_W-1:0] pack;
  logic             pack_nan;
  logic             pack_inf;
  logic             pack_ovf;

  // Handshake control; o_valid doubles as the S2 valid
  assign s2_load  = ~o_valid | i_ready;
  assign o_ready  = ~s1_vld | ~o_valid | i_ready;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Input-side decode in priority order
  always_comb begin
    dec_illegal = (i_sel_man == 2'b01) || (i_sel_exp != i_sel_man[1]);
    dec_kind    = K_NORM;
    dec_sign    = i_norm_sign;
    if (dec_illegal || (i_sel_man == 2'b11)) begin
      dec_kind = K_NAN;
      dec_sign = 1'b0;
    end else if (i_sel_man == 2'b10) begin
      dec_kind = K_INF;
      // The infinite operand supplies the sign
      dec_sign = (&i_exp_a) ? i_sign_a : i_sign_b;
    end else if (i_norm_exp >= EXP_MAX) begin
      dec_kind = K_OVF;
    end else if (i_norm_exp == '0) begin
      dec_kind = K_ZERO;
    end
  end

  // Stage 1: capture inputs and decode decision
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld  <= 1'b0;
      s1_kind <= K_NORM;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_man  <= '0;
    end else if (in_fire) begin
      s1_vld  <= 1'b1;
      s1_kind <= dec_kind;
      s1_sign <= dec_sign;
      s1_exp  <= i_norm_exp[EXP_W-1:0];
      s1_man  <= i_norm_man;
    end else if (s2_load) begin
      s1_vld  <= 1'b0;
    end
  end

  // Pack the S1 decision into the final word
  always_comb begin
    pack     = {s1_sign, s1_exp, s1_man};
    pack_nan = 1'b0;
    pack_inf = 1'b0;
    pack_ovf = 1'b0;
    case (s1_kind)
      K_NAN: begin
        pack     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        pack_nan = 1'b1;
      end
      K_INF: begin
        pack     = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        pack_inf = 1'b1;
      end
      K_OVF: begin
        pack     = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        pack_ovf = 1'b1;
      end
      K_ZERO: pack = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      default: ;
    endcase
  end

  // Stage 2: registered result and flags, held while stalled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_flag_nan <= 1'b0;
      o_flag_inf <= 1'b0;
      o_flag_ovf <= 1'b0;
    end else if (s2_load) begin
      o_valid <= s1_vld;
      if (s1_vld) begin
        o_result   <= pack;
        o_flag_nan <= pack_nan;
        o_flag_inf <= pack_inf;
        o_flag_ovf <= pack_ovf;
      end
    end
  end

  // Sticky error and saturating counters; clear has priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err     <= 1'b0;
      o_cnt_nan <= '0;
      o_cnt_ovf <= '0;
    end else if (i_clr_cnt) begin
      o_err     <= 1'b0;
      o_cnt_nan <= '0;
      o_cnt_ovf <= '0;
    end else begin
      if (in_fire && dec_illegal) o_err <= 1'b1;
      if (out_fire && o_flag_nan && !(&o_cnt_nan))
        o_cnt_nan <= o_cnt_nan + CNT_W'(1);
      if (out_fire && o_flag_ovf && !(&o_cnt_ovf))
        o_cnt_ovf <= o_cnt_ovf + CNT_W'(1);
    end
  end

endmodule

// File: doc/fp_special_result_packer.md
Name: fp_special_result_packer

Overview:
- Output stage of the FP32 adder datapath; the decode side of the special-case detector's select codes.
- Takes the detector's sel_exp/sel_man codes, the operand sign/exponent fields and the normal-path sum, and emits the final packed IEEE-754 single-precision word.
- Adds a 2-stage valid/ready pipeline, exception flags and saturating exception counters used by the sort engine's statistics logic.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width (hidden bit excluded)
CNT_W, 16, width of each exception counter

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  upstream data valid
o_ready  out  1  block can accept this cycle
i_sel_exp  in  1  detector exponent select (1 = result exponent all ones)
i_sel_man  in  2  detector mantissa select: 00 normal, 10 infinity, 11 NaN, 01 illegal
i_sign_a  in  1  operand A sign
i_exp_a  in  EXP_W  operand A exponent
i_sign_b  in  1  operand B sign
i_exp_b  in  EXP_W  operand B exponent
i_norm_sign  in  1  normal-path result sign
i_norm_exp  in  EXP_W+1  normal-path biased exponent; MSB = overflow carry
i_norm_man  in  MAN_W  normal-path rounded mantissa (hidden bit stripped)
o_valid  out  1  result valid
i_ready  in  1  downstream accepts
o_result  out  1+EXP_W+MAN_W  packed {sign, exp, man}
o_flag_nan  out  1  result is NaN (qualified by o_valid)
o_flag_inf  out  1  result is infinity from an infinite operand
o_flag_ovf  out  1  result is infinity from exponent overflow
o_err  out  1  sticky: an illegal select code was seen
i_clr_cnt  in  1  synchronous clear of counters and o_err
o_cnt_nan  out  CNT_W  saturating count of NaN results delivered
o_cnt_ovf  out  CNT_W  saturating count of overflow results delivered

Behaviour:
- Reset (asynchronous, immediate): both stage valids = 0, o_valid = 0, o_result = 0, all flags = 0, o_err = 0, counters = 0. Reset mid-transfer drops in-flight data with no output.
- Pipeline:
  - S1 registers the inputs and the decode decision.
  - S2 registers the packed result and flags.
  - Input accepted when i_valid & o_ready.
  - o_ready = ~s1_vld | ~s2_vld | i_ready (combinational from i_ready).
  - S2 loads when it is empty or i_ready = 1.
  - Latency: 2 cycles from accept to o_valid under no backpressure.
  - Throughput: 1 result per cycle.
- Hold rule: while o_valid & ~i_ready, o_result and flags stay stable. No beat is lost or duplicated.
- Decode, in priority order:
  1. Illegal code (i_sel_man = 01, or i_sel_exp != i_sel_man[1]): canonical NaN 0x7FC00000, o_flag_nan = 1, o_err set.
  2. sel_man = 11: canonical NaN 0x7FC00000 (sign 0, mantissa MSB 1), o_flag_nan = 1.
  3. sel_man = 10: infinity with exp all ones and man 0. Sign = i_sign_a if i_exp_a is all ones, else i_sign_b. o_flag_inf = 1.
  4. sel_man = 00 with i_norm_exp >= 2^EXP_W - 1: infinity with sign i_norm_sign, o_flag_ovf = 1.
  5. sel_man = 00 with i_norm_exp = 0: signed zero {i_norm_sign, 0, 0}; denormals are flushed.
  6. Otherwise: {i_norm_sign, i_norm_exp[EXP_W-1:0], i_norm_man}.
- Exactly one of nan/inf/ovf is set per result, or none.
- Counters:
  - Increment on an output handshake (o_valid & i_ready) with the matching flag.
  - Saturate at all ones; no wrap.
  - i_clr_cnt zeroes both counters and o_err. Clear wins over a same-cycle increment or error.
- o_err is set when the illegal beat is accepted at the input. It stays set until i_clr_cnt or reset.

Test Plan:
- Normal flow: sel 0/00, norm_sign 0, norm_exp 0x080, norm_man 0x200000, i_ready = 1 -> o_result 0x40200000 two cycles after accept; o_valid pulses for 1 cycle; no flags.
- Specials: sel_man 10, exp_a 0xFF with sign_a 1 -> 0xFF800000, o_flag_inf. sel_man 11 -> 0x7FC00000, o_flag_nan, o_cnt_nan increments. norm_exp 0x100 -> 0x7F800000, o_flag_ovf.
- Backpressure: stream 4 beats while i_ready is held low for 5 cycles -> o_ready drops after 2 beats are buffered; o_result is stable while stalled; all 4 beats emerge in order, none lost or duplicated.
- Illegal and clear: sel_man 01 -> NaN output, o_err = 1 and stays set. Then i_clr_cnt -> o_err = 0 and both counters = 0. A same-cycle NaN handshake is not counted.
- Saturation: preload traffic driving o_cnt_ovf to 0xFFFF, then one more overflow result -> counter stays 0xFFFF.
- Reset mid-operation: assert i_rst with both stages full -> o_valid = 0 immediately; no output after release until new input is accepted.
